// File: rtl/pattern_gen_multi.sv
// ---------------------------------------------------------------------------
// pattern_gen_multi
//
// Streams one frame of test pixels (linear address plus pixel value) towards
// the frame-buffer write port, one pixel per accepted beat. Supports four
// pattern modes, start/continuous control, ready backpressure gated by the
// clock-enable strobe, and start-of-frame / end-of-line / end-of-frame
// markers.
//
// Ports:
//   clk           system clock
//   i_rst_n       asynchronous active-low reset
//   i_enable      clock-enable strobe; a beat may only be accepted when high
//   i_start       one-cycle pulse, starts a frame when idle
//   i_continuous  1 = roll straight into the next frame after the last pixel
//   i_mode        0 solid, 1 horizontal gradient, 2 vertical gradient,
//                 3 checkerboard (sampled at frame start only)
//   i_ready       downstream can take the current pixel
//   o_valid       o_addr/o_data hold a valid pixel
//   o_addr        linear pixel address y*H_RES+x
//   o_data        pixel value
//   o_sof         current pixel is (0,0)
//   o_eol         current pixel is the last one of its line
//   o_eof         current pixel is the last one of the frame
//   o_busy        a frame is being streamed
//   o_frame_cnt   number of completed frames, wraps at 255
// ---------------------------------------------------------------------------
module pattern_gen_multi #(
    parameter int H_RES        = 320,
    parameter int V_RES        = 240,
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 8,
    parameter int CHECKER_LOG2 = 4,
    parameter logic [DATA_WIDTH-1:0] SOLID_VALUE = DATA_WIDTH'(8'h80)
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic                  i_continuous,
    input  logic [1:0]            i_mode,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic                  o_busy,
    output logic [7:0]            o_frame_cnt
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [1:0]      mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic            valid_d;
    logic [7:0]      cnt_d;

    logic            accept;
    logic            last_x;
    logic            last_y;

    // Pixel value for a given coordinate. The size casts zero-extend or
    // truncate the coordinates so narrow counters still index the
    // checkerboard bit and the gradients wrap every 2**DATA_WIDTH pixels.
    function automatic logic [DATA_WIDTH-1:0] pixel_value(
        input logic [1:0]    mode,
        input logic [XW-1:0] px,
        input logic [YW-1:0] py
    );
        logic [DATA_WIDTH-1:0] value;
        case (mode)
            2'd0:    value = SOLID_VALUE;
            2'd1:    value = DATA_WIDTH'(px);
            2'd2:    value = DATA_WIDTH'(py);
            default: value = (1'(px >> CHECKER_LOG2) ^ 1'(py >> CHECKER_LOG2))
                             ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
        endcase
        return value;
    endfunction

    assign accept = o_valid & i_ready & i_enable;
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);

    // Markers decode the registered coordinates so they line up with the
    // pixel currently presented.
    assign o_sof  = o_valid & (x_q == '0) & (y_q == '0);
    assign o_eol  = o_valid & last_x;
    assign o_eof  = o_valid & last_x & last_y;
    assign o_busy = (state_q == RUN);

    // Next-state logic. Everything holds unless a frame is started or a
    // beat is accepted, which gives backpressure for free. The address is a
    // running counter rather than y*H_RES+x.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        addr_d  = o_addr;
        data_d  = o_data;
        valid_d = o_valid;
        cnt_d   = o_frame_cnt;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    mode_d  = i_mode;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    data_d  = pixel_value(i_mode, '0, '0);
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_x && last_y) begin
                        cnt_d = o_frame_cnt + 8'd1;
                        if (i_continuous) begin
                            mode_d = i_mode;
                            x_d    = '0;
                            y_d    = '0;
                            addr_d = '0;
                            data_d = pixel_value(i_mode, '0, '0);
                        end else begin
                            valid_d = 1'b0;
                            state_d = DONE;
                        end
                    end else begin
                        addr_d = o_addr + ADDR_WIDTH'(1);
                        if (last_x) begin
                            x_d    = '0;
                            y_d    = y_q + YW'(1);
                            data_d = pixel_value(mode_q, '0, y_q + YW'(1));
                        end else begin
                            x_d    = x_q + XW'(1);
                            data_d = pixel_value(mode_q, x_q + XW'(1), y_q);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            o_addr      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            o_addr      <= addr_d;
            o_data      <= data_d;
            o_valid     <= valid_d;
            o_frame_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pattern_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pattern_gen_multi
//
// Self-checking bench for pattern_gen_multi on an 8x4 frame with a 2-pixel
// checkerboard. Stimulus pushes whole expected frames (computed from the
// pattern rules with plain arithmetic) into a queue; a monitor pops one entry
// per accepted beat and also checks that outputs hold while stalled.
// ---------------------------------------------------------------------------
module tb_pattern_gen_multi;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int CL = 1;
    localparam int N  = H * V;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_enable;
    logic          i_start;
    logic          i_continuous;
    logic [1:0]    i_mode;
    logic          i_ready;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;
    logic          o_busy;
    logic [7:0]    o_frame_cnt;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
        logic [7:0]    cnt;
    } beat_t;

    beat_t      exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         model_frames = 0;
    logic [1:0] frame_modes[8];
    bit         rand_ready = 1'b0;
    bit         en_div = 1'b0;

    pattern_gen_multi #(
        .H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CHECKER_LOG2(CL), .SOLID_VALUE(8'h80)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_start(i_start),
        .i_continuous(i_continuous), .i_mode(i_mode), .i_ready(i_ready),
        .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data), .o_sof(o_sof),
        .o_eol(o_eol), .o_eof(o_eof), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] model_pixel(input int mode, input int x, input int y);
        case (mode)
            0:       return 8'h80;
            1:       return 8'(x % 256);
            2:       return 8'(y % 256);
            default: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // One full frame of expected beats, stamped with the completed-frame
    // count the DUT should show while that frame streams.
    task automatic pushFrame(input int mode);
        beat_t b;
        for (int p = 0; p < N; p++) begin
            b.addr = AW'(p);
            b.data = model_pixel(mode, p % H, p / H);
            b.sof  = (p == 0);
            b.eol  = ((p % H) == H - 1);
            b.eof  = (p == N - 1);
            b.cnt  = 8'(model_frames);
            exp_q.push_back(b);
        end
        model_frames++;
    endtask

    // Ready / enable driver, updated just after each rising edge.
    initial begin
        bit en_phase;
        en_phase = 1'b0;
        i_ready  = 1'b1;
        i_enable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (en_div) begin
                en_phase = ~en_phase;
                i_enable = en_phase;
            end else begin
                i_enable = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop on accept, hold check on stall.
    initial begin
        bit            pend;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        beat_t         e;
        beat_t         act;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    checkOutput("hold_valid", 64'(o_valid), 64'(1));
                    checkOutput("hold_addr", 64'(o_addr), 64'(p_addr));
                    checkOutput("hold_data", 64'(o_data), 64'(p_data));
                end
                if (o_valid && i_ready && i_enable) begin
                    act = {o_addr, o_data, o_sof, o_eol, o_eof, o_frame_cnt};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_beat actual=%0h expected=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", 64'(act), 64'(e));
                        checkOutput("beat_busy", 64'(o_busy), 64'(1));
                    end
                end
                pend   = o_valid && !(i_ready && i_enable);
                p_addr = o_addr;
                p_data = o_data;
            end
        end
    end

    task automatic pulseStart(input logic [1:0] mode, input bit cont);
        @(posedge clk);
        #1;
        i_mode       = mode;
        i_continuous = cont;
        i_start      = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic waitAddr(input int cnt, input int addr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_valid && o_addr == AW'(addr) && o_frame_cnt == 8'(cnt)) && n < BUDGET);
        if (n >= BUDGET) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_addr_timeout actual=timeout expected=addr %0d", addr);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((o_busy || o_valid || exp_q.size() != 0) && n < BUDGET);
        if (n >= BUDGET) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_idle_timeout actual=busy expected=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    // Streams nframes frames using frame_modes[]. The next frame's mode is
    // applied mid-frame (addr 10) so it must only take effect at the frame
    // boundary; continuous is dropped mid-way through the last frame.
    task automatic applyStimulus(input int nframes);
        int base;
        base = model_frames;
        for (int f = 0; f < nframes; f++) pushFrame(frame_modes[f]);
        pulseStart(frame_modes[0], nframes > 1);
        for (int f = 0; f < nframes; f++) begin
            waitAddr(base + f, 10);
            if (f + 1 < nframes) begin
                i_mode = frame_modes[f + 1];
            end else begin
                i_continuous = 1'b0;
                i_mode       = 2'($urandom);
            end
        end
        waitIdle();
        checkOutput("frame_cnt_after", 64'(o_frame_cnt), 64'(8'(model_frames)));
        checkOutput("valid_after", 64'(o_valid), 64'(0));
        checkOutput("busy_after", 64'(o_busy), 64'(0));
    endtask

    task automatic measureRun(output int cycles);
        int n;
        n = 0;
        cycles = 0;
        while (!o_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        while (o_valid && n < BUDGET) begin
            cycles++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int run_len;
        int nf;
        int seen_valid;

        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_continuous = 1'b0;
        i_mode       = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(o_valid), 64'(0));
        checkOutput("reset_addr", 64'(o_addr), 64'(0));
        checkOutput("reset_data", 64'(o_data), 64'(0));
        checkOutput("reset_cnt", 64'(o_frame_cnt), 64'(0));
        checkOutput("reset_flags", 64'({o_sof, o_eol, o_eof, o_busy}), 64'(0));
        i_rst_n = 1'b1;

        // Horizontal gradient, then checkerboard, single frames.
        frame_modes[0] = 2'd1;
        applyStimulus(1);
        frame_modes[0] = 2'd3;
        applyStimulus(1);

        // Three back-to-back solid frames must occupy exactly 3*N cycles.
        frame_modes[0] = 2'd0;
        frame_modes[1] = 2'd0;
        frame_modes[2] = 2'd0;
        fork
            applyStimulus(3);
            measureRun(run_len);
        join
        checkOutput("continuous_run_length", 64'(run_len), 64'(3 * N));

        // Random ready with divided enable; mode 1 -> 2 change mid-frame.
        rand_ready     = 1'b1;
        en_div         = 1'b1;
        frame_modes[0] = 2'd1;
        frame_modes[1] = 2'd2;
        applyStimulus(2);

        // Randomised modes and frame counts.
        for (int t = 0; t < 4; t++) begin
            en_div = 1'($urandom_range(0, 1));
            nf     = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) frame_modes[f] = 2'($urandom);
            applyStimulus(nf);
        end

        // Asynchronous reset in the middle of a frame.
        pushFrame(1);
        pulseStart(2'd1, 1'b0);
        waitAddr(model_frames - 1, 17);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(o_valid), 64'(0));
        checkOutput("midreset_addr", 64'(o_addr), 64'(0));
        checkOutput("midreset_data", 64'(o_data), 64'(0));
        checkOutput("midreset_cnt", 64'(o_frame_cnt), 64'(0));
        checkOutput("midreset_flags", 64'({o_sof, o_eol, o_eof, o_busy}), 64'(0));
        exp_q.delete();
        model_frames = 0;
        repeat (3) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        seen_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_valid) seen_valid++;
        end
        checkOutput("no_output_without_start", 64'(seen_valid), 64'(0));
        checkOutput("cnt_after_reset", 64'(o_frame_cnt), 64'(0));

        // Fresh frame after reset counts from zero.
        rand_ready     = 1'b0;
        en_div         = 1'b0;
        frame_modes[0] = 2'd2;
        applyStimulus(1);

        checkOutput("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_gen_multi.md
Name: pattern_gen_multi

Overview:
- Parametrised successor to the single-pattern address/data generator.
- Streams one full frame of test pixels (address plus data) into the frame buffer or the IPM pipeline input, one pixel per accepted beat.
- Adds selectable pattern modes, configurable resolution, start/continuous control, ready backpressure, and frame/line markers.
- Sits between the clock-enable divider and the frame-buffer write port.

Parameters:
H_RES, 320, active pixels per line
V_RES, 240, lines per frame (H_RES*V_RES must be <= 2**ADDR_WIDTH)
ADDR_WIDTH, 17, frame-buffer address width
DATA_WIDTH, 8, pixel data width
CHECKER_LOG2, 4, log2 of checkerboard square size in pixels
SOLID_VALUE, 8'h80, pixel value in solid mode (DATA_WIDTH bits)

Ports:
clk  input  1  system clock (100 MHz)
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  clock-enable strobe from the clock-enable divider; advance allowed only when high
i_start  input  1  one-cycle pulse; starts a frame from IDLE
i_continuous  input  1  1 = restart the next frame automatically after the last pixel
i_mode  input  2  0 solid, 1 horizontal gradient, 2 vertical gradient, 3 checkerboard
i_ready  input  1  downstream can accept the current pixel
o_valid  output  1  o_addr/o_data hold a valid pixel
o_addr  output  ADDR_WIDTH  linear pixel address y*H_RES+x
o_data  output  DATA_WIDTH  pixel value
o_sof  output  1  high while the current pixel is (0,0)
o_eol  output  1  high while the current pixel is x = H_RES-1
o_eof  output  1  high while the current pixel is the last pixel of the frame
o_busy  output  1  high in RUN
o_frame_cnt  output  8  completed frames, wraps at 255

Behaviour:
- Reset (async, i_rst_n = 0): state IDLE; x, y, o_addr, o_data, o_frame_cnt = 0; o_valid, o_sof, o_eol, o_eof, o_busy = 0.
- Beat accept: o_valid & i_ready & i_enable in the same cycle. Outputs are registered and held stable until accepted.
- States:
  - IDLE: o_valid = 0. On i_start, latch i_mode into mode_q; load x = y = addr = 0; compute pixel 0. Next cycle enters RUN with o_valid = 1 and o_sof = 1 (1-cycle latency).
  - RUN: on accept, if not the last pixel:
    - x++;
    - if x was H_RES-1, then x = 0 and y++;
    - addr++ (running counter, no multiplier);
    - new pixel data is registered the same edge.
  - RUN, accept of the last pixel (x = H_RES-1, y = V_RES-1):
    - o_frame_cnt++;
    - if i_continuous, re-latch i_mode, reload pixel 0, stay in RUN with no gap cycle;
    - else go to DONE with o_valid = 0.
  - DONE: one cycle, o_busy = 0, then IDLE.
- i_mode changes mid-frame have no effect until the next frame. i_start is ignored outside IDLE.
- Data rules, using the next pixel's coordinates:
  - solid = SOLID_VALUE;
  - horizontal gradient = x[DATA_WIDTH-1:0] (wraps every 2**DATA_WIDTH pixels);
  - vertical gradient = y[DATA_WIDTH-1:0];
  - checkerboard = all-ones if x[CHECKER_LOG2] ^ y[CHECKER_LOG2], else 0.
- Markers: o_sof, o_eol, o_eof are combinational decodes of the registered x/y, qualified by o_valid.
- Backpressure: i_ready = 0 or i_enable = 0 freezes every output and counter.
- Reset mid-frame: immediate return to reset values. No partial-frame count.
- Width: x needs clog2(H_RES) bits, y needs clog2(V_RES) bits. o_addr never exceeds H_RES*V_RES-1.

Test Plan:
- H_RES=8, V_RES=4, mode 1, i_ready = i_enable = 1, one i_start -> 32 beats: addr 0..31, data 0..7 repeating, o_eol at addr 7/15/23/31, o_eof at 31, o_frame_cnt = 1, then IDLE.
- Mode 3, CHECKER_LOG2=1, 8x4 -> row 0 data 00,00,FF,FF,00,00,FF,FF; row 2 inverted.
- i_continuous = 1, mode 0 -> 3 back-to-back frames with no o_valid gap; addr wraps 31 -> 0 with o_sof; o_frame_cnt = 3.
- Toggle i_ready randomly and use the clock-enable divider with WAIT=1 -> o_addr/o_data stable while not accepted; accepted sequence still exactly 0..31.
- Change i_mode from 1 to 2 at addr 10 -> frame stays horizontal gradient; next continuous frame outputs y values.
- Assert i_rst_n = 0 at addr 17 -> outputs zero asynchronously; after release, no output until i_start; o_frame_cnt = 0.
